fpu_add_arbiter: RTL

- Shares one combinational single-precision adder (IEEE-754; operands A, B; 2-bit round mode; outputs result, error, overflow) between two requesters.
- Round-robin arbitration with valid/ready handshakes.
- Latches the granted operands and holds them on the adder inputs for a fixed settle window, then captures the adder outputs.
- Returns the captured result on a single response channel tagged with the requester ID; sits between requesters and the adder instance.

---
 rtl/fpu_add_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fpu_add_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_add_arbiter
//  Description : Round-robin front end that shares one combinational
//                single-precision adder between two requesters. The granted
//                operands are held on the adder for EVAL_CYCLES cycles, the
//                adder outputs are captured, and the result is returned on a
//                single response channel tagged with the requester ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_add_arbiter #(
  parameter int unsigned EVAL_CYCLES = 1   // legal range 1..15
) (
  input  logic        clk,
  input  logic        reset,
  // requester 0
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_round,
  // requester 1
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_round,
  // shared adder
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic [1:0]  add_round_mode,
  input  logic [31:0] add_result,
  input  logic        add_error,
  input  logic        add_overflow,
  // response channel
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_error,
  output logic        rsp_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter reload: the first EVAL cycle already counts as one settle cycle.
  localparam logic [3:0] c_cnt_init = 4'(EVAL_CYCLES - 1);

  state_t      r_state;
  logic        r_last_grant;
  logic        r_id;
  logic [3:0]  r_cnt;
  logic [31:0] r_add_a;
  logic [31:0] r_add_b;
  logic [1:0]  r_add_rm;
  logic [31:0] r_rsp_result;
  logic        r_rsp_id;
  logic        r_rsp_error;
  logic        r_rsp_overflow;
  logic        r_rsp_valid;
  logic        r_busy;

  logic        w_idle;
  logic        w_pick0;
  logic        w_pick1;
  logic        w_acc0;
  logic        w_acc1;

  // Arbitration: a lone requester wins; on contention the one not granted
  // last time wins. Grants are suppressed while reset is asserted.
  assign w_idle     = (r_state == ST_IDLE) && !reset;
  assign w_pick0    = req0_valid && (!req1_valid || r_last_grant);
  assign w_pick1    = req1_valid && (!req0_valid || !r_last_grant);
  assign req0_ready = w_idle && w_pick0;
  assign req1_ready = w_idle && w_pick1;
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;

  // Control FSM with operand latch, settle counter and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_last_grant   <= 1'b1;
      r_id           <= 1'b0;
      r_cnt          <= 4'd0;
      r_add_a        <= 32'd0;
      r_add_b        <= 32'd0;
      r_add_rm       <= 2'd0;
      r_rsp_result   <= 32'd0;
      r_rsp_id       <= 1'b0;
      r_rsp_error    <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_valid    <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_acc0 || w_acc1) begin
            r_add_a      <= w_acc1 ? req1_a     : req0_a;
            r_add_b      <= w_acc1 ? req1_b     : req0_b;
            r_add_rm     <= w_acc1 ? req1_round : req0_round;
            r_id         <= w_acc1;
            r_last_grant <= w_acc1;
            r_cnt        <= c_cnt_init;
            r_busy       <= 1'b1;
            r_state      <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_result   <= add_result;
            r_rsp_error    <= add_error;
            r_rsp_overflow <= add_overflow;
            r_rsp_id       <= r_id;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end
        end
        ST_RESP: begin
          // Arbitration resumes only in the cycle after the handshake.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign add_a          = r_add_a;
  assign add_b          = r_add_b;
  assign add_round_mode = r_add_rm;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_id         = r_rsp_id;
  assign rsp_result     = r_rsp_result;
  assign rsp_error      = r_rsp_error;
  assign rsp_overflow   = r_rsp_overflow;
  assign busy           = r_busy;

endmodule
`default_nettype wire
